// File: rtl/lc3_ctrl_seq.sv
// LC-3 control sequencer: Moore FSM for fetch, decode and control-flow execution.
// Non-control-flow opcodes are handed to the execute unit via exec_start/exec_done.
module lc3_ctrl_seq #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] ir,
  input  logic [2:0]  nzp,
  input  logic        mem_ready,
  input  logic        exec_done,
  output logic [1:0]  pc_mux,
  output logic        ld_pc,
  output logic        ld_mar,
  output logic        gate_pc,
  output logic        gate_base,
  output logic        mem_req,
  output logic        ld_ir,
  output logic        ld_r7,
  output logic        exec_start,
  output logic        halted,
  output logic        fault,
  output logic [3:0]  state_o
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH1    = 4'd1,
    S_FETCH2    = 4'd2,
    S_FETCH3    = 4'd3,
    S_DECODE    = 4'd4,
    S_BR_TAKE   = 4'd5,
    S_JMP_EX    = 4'd6,
    S_JSR_SAVE  = 4'd7,
    S_JSR_JUMP  = 4'd8,
    S_EXEC      = 4'd9,
    S_EXEC_WAIT = 4'd10,
    S_HALT      = 4'd11,
    S_FAULT     = 4'd12
  } state_e;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_BUS = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_RTI = 4'b1000;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_RES = 4'b1101;
  localparam logic [3:0] OP_TRP = 4'b1111;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [TO_W-1:0] to_q, to_d;

  // BaseR (ir[8:6]) is consumed by the register file, not by the sequencer.
  logic unused_ir8;
  assign unused_ir8 = ir[8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      to_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    // NOTE: defaults assigned first so no path through the case leaves a variable unassigned (no latches).
    state_d = state_q;
    to_d    = to_q;
    case (state_q)
      S_IDLE:      if (run) state_d = S_FETCH1;
      S_FETCH1: begin
        state_d = S_FETCH2;
        to_d    = '0;
      end
      S_FETCH2: begin
        if (mem_ready) begin
          state_d = S_FETCH3;
        end else begin
          to_d = to_q + 1'b1;
          if (to_q == TO_LAST) state_d = S_FAULT;
        end
      end
      S_FETCH3:    state_d = S_DECODE;
      S_DECODE: begin
        case (ir[15:12])
          OP_BR:           state_d = (|(ir[11:9] & nzp)) ? S_BR_TAKE : S_FETCH1;
          OP_JMP:          state_d = S_JMP_EX;
          OP_JSR:          state_d = S_JSR_SAVE;
          OP_TRP:          state_d = (ir[7:0] == 8'h25) ? S_HALT : S_EXEC;
          OP_RTI, OP_RES:  state_d = S_FAULT;
          default:         state_d = S_EXEC;
        endcase
      end
      S_BR_TAKE,
      S_JMP_EX,
      S_JSR_JUMP:  state_d = S_FETCH1;
      S_JSR_SAVE:  state_d = S_JSR_JUMP;
      S_EXEC:      state_d = S_EXEC_WAIT;
      S_EXEC_WAIT: if (exec_done) state_d = S_FETCH1;
      S_HALT:      state_d = S_HALT;
      S_FAULT:     state_d = S_FAULT;
      default:     state_d = S_FAULT;
    endcase
  end

  // Strobes depend only on the state register, so reset clears them without waiting for a clock.
  always_comb begin
    pc_mux     = PC_INC;
    ld_pc      = 1'b0;
    ld_mar     = 1'b0;
    gate_pc    = 1'b0;
    gate_base  = 1'b0;
    mem_req    = 1'b0;
    ld_ir      = 1'b0;
    ld_r7      = 1'b0;
    exec_start = 1'b0;
    halted     = 1'b0;
    fault      = 1'b0;
    case (state_q)
      S_FETCH1: begin
        ld_mar  = 1'b1;
        gate_pc = 1'b1;
        ld_pc   = 1'b1;
        pc_mux  = PC_INC;
      end
      S_FETCH2:    mem_req = 1'b1;
      S_FETCH3:    ld_ir   = 1'b1;
      S_BR_TAKE: begin
        ld_pc  = 1'b1;
        pc_mux = PC_JMP;
      end
      S_JMP_EX: begin
        gate_base = 1'b1;
        ld_pc     = 1'b1;
        pc_mux    = PC_BUS;
      end
      S_JSR_SAVE: begin
        gate_pc = 1'b1;
        ld_r7   = 1'b1;
      end
      S_JSR_JUMP: begin
        ld_pc = 1'b1;
        if (ir[11]) begin
          pc_mux = PC_JMP;
        end else begin
          pc_mux    = PC_BUS;
          gate_base = 1'b1;
        end
      end
      S_EXEC:      exec_start = 1'b1;
      S_HALT:      halted     = 1'b1;
      S_FAULT:     fault      = 1'b1;
      default:     ;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_lc3_ctrl_seq.sv
// Directed self-checking bench for lc3_ctrl_seq: fetch, branch, jumps, stalls, timeout, halt, faults, async reset.
module tb_lc3_ctrl_seq;

  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [15:0] ir;
  logic [2:0]  nzp;
  logic        mem_ready;
  logic        exec_done;
  logic [1:0]  pc_mux;
  logic        ld_pc, ld_mar, gate_pc, gate_base, mem_req, ld_ir, ld_r7;
  logic        exec_start, halted, fault;
  logic [3:0]  state_o;

  int checks = 0;
  int errors = 0;
  int ld_pc_cnt = 0;

  lc3_ctrl_seq #(.TIMEOUT(TIMEOUT), .TO_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .ir         (ir),
    .nzp        (nzp),
    .mem_ready  (mem_ready),
    .exec_done  (exec_done),
    .pc_mux     (pc_mux),
    .ld_pc      (ld_pc),
    .ld_mar     (ld_mar),
    .gate_pc    (gate_pc),
    .gate_base  (gate_base),
    .mem_req    (mem_req),
    .ld_ir      (ld_ir),
    .ld_r7      (ld_r7),
    .exec_start (exec_start),
    .halted     (halted),
    .fault      (fault),
    .state_o    (state_o)
  );

  logic [11:0] outs;
  assign outs = {pc_mux, ld_pc, ld_mar, gate_pc, gate_base, mem_req, ld_ir, ld_r7,
                 exec_start, halted, fault};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset pulse (outputs must be zero while rst is high), then start a run.
  task automatic start();
    rst = 1'b1;
    #2;
    check("rst_state", 32'(state_o), 0);
    check("rst_outs", 32'(outs), 0);
    rst = 1'b0;
    mem_ready = 1'b1;
    run = 1'b1;
    tick();
    run = 1'b0;
    check("start_fetch1", 32'(state_o), 1);
  endtask

  // From FETCH1 with memory ready: FETCH2, FETCH3, DECODE.
  task automatic to_decode(input logic [15:0] instr);
    mem_ready = 1'b1;
    ir = instr;
    tick();
    tick();
    tick();
    check("decode", 32'(state_o), 4);
  endtask

  // Per-cycle invariants: exclusive bus gates, ld_pc only in PC-loading states.
  always @(negedge clk) begin
    check("gate_excl", 32'(gate_pc & gate_base), 0);
    if (ld_pc) begin
      ld_pc_cnt++;
      check("ld_pc_state", 32'(state_o inside {4'd1, 4'd5, 4'd6, 4'd8}), 1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int cnt;
    rst = 1'b1; run = 1'b0; ir = 16'h0000; nzp = 3'b000;
    mem_ready = 1'b1; exec_done = 1'b0;

    // Reset and a plain ADD through the execute handshake
    start();
    check("f1_ld_pc", 32'(ld_pc), 1);
    check("f1_pc_mux", 32'(pc_mux), 0);
    check("f1_ld_mar", 32'(ld_mar), 1);
    check("f1_gate_pc", 32'(gate_pc), 1);
    n0 = ld_pc_cnt;
    ir = 16'h1000;
    tick(); check("f2_state", 32'(state_o), 2); check("f2_mem_req", 32'(mem_req), 1);
    tick(); check("f3_state", 32'(state_o), 3); check("f3_ld_ir", 32'(ld_ir), 1);
    tick(); check("dec_state", 32'(state_o), 4); check("dec_outs", 32'(outs), 0);
    tick(); check("exec_state", 32'(state_o), 9); check("exec_start", 32'(exec_start), 1);
    tick(); check("wait_state", 32'(state_o), 10); check("wait_start_lo", 32'(exec_start), 0);
    exec_done = 1'b1;
    tick(); exec_done = 1'b0;
    check("add_back_f1", 32'(state_o), 1);
    check("add_one_ld_pc", 32'(ld_pc_cnt - n0), 1);

    // Branches
    nzp = 3'b010; to_decode(16'h0A05); tick();
    check("br_not_taken", 32'(state_o), 1);
    nzp = 3'b100; to_decode(16'h0A05); tick();
    check("br_take_state", 32'(state_o), 5);
    check("br_take_ld_pc", 32'(ld_pc), 1);
    check("br_take_mux", 32'(pc_mux), 2);
    tick(); check("br_take_f1", 32'(state_o), 1);
    nzp = 3'b111; to_decode(16'h0000); tick();
    check("br_nop", 32'(state_o), 1);

    // JSR (PC-relative)
    to_decode(16'h4802); tick();
    check("jsr_save", 32'(state_o), 7);
    check("jsr_save_gate_pc", 32'(gate_pc), 1);
    check("jsr_save_ld_r7", 32'(ld_r7), 1);
    check("jsr_save_ld_pc", 32'(ld_pc), 0);
    tick();
    check("jsr_jump", 32'(state_o), 8);
    check("jsr_jump_mux", 32'(pc_mux), 2);
    check("jsr_jump_ld_pc", 32'(ld_pc), 1);
    check("jsr_jump_base", 32'(gate_base), 0);
    tick(); check("jsr_f1", 32'(state_o), 1);

    // JSRR (register)
    to_decode(16'h4080); tick();
    check("jsrr_save", 32'(state_o), 7);
    tick();
    check("jsrr_jump", 32'(state_o), 8);
    check("jsrr_mux", 32'(pc_mux), 1);
    check("jsrr_base", 32'(gate_base), 1);
    check("jsrr_gate_pc", 32'(gate_pc), 0);
    tick(); check("jsrr_f1", 32'(state_o), 1);

    // RET
    to_decode(16'hC1C0); tick();
    check("ret_state", 32'(state_o), 6);
    check("ret_mux", 32'(pc_mux), 1);
    check("ret_base", 32'(gate_base), 1);
    check("ret_ld_pc", 32'(ld_pc), 1);
    tick(); check("ret_f1", 32'(state_o), 1);

    // Memory stall: ready low 10 cycles, high on the 11th
    mem_ready = 1'b0; ir = 16'h1000;
    tick();
    cnt = 0;
    for (int i = 0; i <= 10; i++) begin
      if (state_o == 4'd2 && mem_req) cnt++;
      if (i == 10) mem_ready = 1'b1;
      tick();
    end
    check("stall_cycles", 32'(cnt), 11);
    check("stall_f3", 32'(state_o), 3);
    tick(); tick(); check("stall_exec", 32'(state_o), 9);
    tick(); exec_done = 1'b1; tick(); exec_done = 1'b0;
    check("stall_done_f1", 32'(state_o), 1);

    // Non-HALT TRAP, then async reset during EXEC_WAIT
    to_decode(16'hF023); tick();
    check("trap23_exec", 32'(state_o), 9);
    tick(); tick();
    check("trap23_waits", 32'(state_o), 10);
    #1 rst = 1'b1;
    #1 check("arst_wait_state", 32'(state_o), 0);
    check("arst_wait_outs", 32'(outs), 0);
    rst = 1'b0; run = 1'b1;
    tick(); run = 1'b0;
    check("arst_wait_restart", 32'(state_o), 1);

    // HALT
    to_decode(16'hF025);
    n0 = ld_pc_cnt;
    tick();
    check("halt_state", 32'(state_o), 11);
    check("halt_flag", 32'(halted), 1);
    run = 1'b1; exec_done = 1'b1; mem_ready = 1'b1;
    repeat (5) tick();
    run = 1'b0; exec_done = 1'b0;
    check("halt_sticky_state", 32'(state_o), 11);
    check("halt_sticky_flag", 32'(halted), 1);
    check("halt_no_ld_pc", 32'(ld_pc_cnt - n0), 0);

    // Illegal opcodes
    start(); to_decode(16'h8000); tick();
    check("rti_fault_state", 32'(state_o), 12);
    check("rti_fault", 32'(fault), 1);
    start(); to_decode(16'hD000); tick();
    check("res_fault_state", 32'(state_o), 12);
    check("res_fault", 32'(fault), 1);

    // Async reset during FETCH2
    start(); mem_ready = 1'b0;
    tick(); check("arst_f2_pre", 32'(state_o), 2);
    tick(); tick();
    #1 rst = 1'b1;
    #1 check("arst_f2_state", 32'(state_o), 0);
    check("arst_f2_mem_req", 32'(mem_req), 0);
    rst = 1'b0; run = 1'b1; mem_ready = 1'b1;
    tick(); run = 1'b0;
    check("arst_f2_restart", 32'(state_o), 1);

    // Fetch timeout: FAULT after TIMEOUT cycles in FETCH2
    mem_ready = 1'b0;
    tick();
    repeat (TIMEOUT - 1) tick();
    check("to_last_f2", 32'(state_o), 2);
    tick();
    check("to_fault_state", 32'(state_o), 12);
    check("to_fault", 32'(fault), 1);
    check("to_mem_req_off", 32'(mem_req), 0);
    mem_ready = 1'b1;
    repeat (3) tick();
    check("to_fault_sticky", 32'(fault), 1);

    // mem_ready on the timeout cycle wins
    start(); mem_ready = 1'b0;
    tick();
    repeat (TIMEOUT - 1) tick();
    check("race_last_f2", 32'(state_o), 2);
    mem_ready = 1'b1;
    tick();
    check("race_f3", 32'(state_o), 3);
    check("race_no_fault", 32'(fault), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lc3_ctrl_seq.md
Name: lc3_ctrl_seq

Overview:
- Moore FSM sequencing the LC-3 program-counter datapath: instruction fetch, decode, and control-flow execution (BR, JMP/RET, JSR/JSRR, TRAP HALT).
- Drives the PC block's pc_mux/ld_pc, plus MAR, memory request, IR, R7 and gate strobes.
- Hands all non-control-flow opcodes to the execute unit through a start/done handshake.

Parameters:
- TIMEOUT, 255: max cycles in FETCH2 with mem_ready low before entering FAULT.
- TO_W, 8: width of the timeout counter; must satisfy TIMEOUT < 2^TO_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- run  in  1  start request, sampled only in IDLE.
- ir  in  16  instruction register contents; valid from DECODE onward.
- nzp  in  3  condition codes {n,z,p}.
- mem_ready  in  1  memory read data valid.
- exec_done  in  1  execute unit finished current instruction.
- pc_mux  out  2  00 = pc+1, 01 = bus, 10 = jmp_addr.
- ld_pc  out  1  PC load enable.
- ld_mar  out  1  MAR load.
- gate_pc  out  1  drive PC onto bus.
- gate_base  out  1  regfile drives BaseR (ir[8:6]) onto bus.
- mem_req  out  1  memory read request.
- ld_ir  out  1  IR load.
- ld_r7  out  1  write bus into R7.
- exec_start  out  1  one-cycle start pulse to the execute unit.
- halted  out  1  sticky; set in HALT.
- fault  out  1  sticky; set in FAULT.
- state_o  out  4  current state encoding.

Behaviour:
- Outputs are decoded purely from the state register (Moore). rst forces IDLE immediately, so every output is 0 and state_o = 0 during and after reset, including mid-fetch or mid-exec.
- Timeout counter is cleared on reset and on every entry to FETCH2.
- State encodings: IDLE=0, FETCH1=1, FETCH2=2, FETCH3=3, DECODE=4, BR_TAKE=5, JMP_EX=6, JSR_SAVE=7, JSR_JUMP=8, EXEC=9, EXEC_WAIT=10, HALT=11, FAULT=12. Codes 13-15 go to FAULT.
- IDLE: all outputs 0. run=1 → FETCH1.
- FETCH1 (1 cycle): ld_mar=1, gate_pc=1, ld_pc=1, pc_mux=00. MAR gets the old PC and the PC increments on the same edge. → FETCH2.
- FETCH2: mem_req=1 held.
  - mem_ready=1 → FETCH3.
  - Otherwise the counter increments; when it reaches TIMEOUT → FAULT.
  - mem_ready arriving in the same cycle the counter hits TIMEOUT: mem_ready wins.
- FETCH3 (1 cycle): ld_ir=1. → DECODE.
- DECODE (1 cycle, no strobes): dispatch on ir[15:12].
  - 0000 BR: if (ir[11:9] & nzp) != 0 → BR_TAKE, else → FETCH1. nzp=000 in ir is never taken.
  - 1100 JMP/RET → JMP_EX.
  - 0100 JSR/JSRR → JSR_SAVE.
  - 1111 TRAP: if ir[7:0]=0x25 → HALT, else → EXEC.
  - 1000 RTI and 1101 reserved → FAULT.
  - All others → EXEC.
- BR_TAKE: ld_pc=1, pc_mux=10. → FETCH1.
- JMP_EX: gate_base=1, ld_pc=1, pc_mux=01. → FETCH1.
- JSR_SAVE: gate_pc=1, ld_r7=1 (R7 gets the incremented PC). → JSR_JUMP.
- JSR_JUMP: ld_pc=1.
  - ir[11]=1: pc_mux=10.
  - ir[11]=0: pc_mux=01 and gate_base=1.
  - JSRR with BaseR=R7 jumps to the newly saved return address (accepted deviation).
  - → FETCH1.
- EXEC: exec_start=1 for exactly one cycle. → EXEC_WAIT.
- EXEC_WAIT: → FETCH1 on exec_done=1. exec_done is ignored in every other state.
- HALT: halted=1; terminal until rst.
- FAULT: fault=1; terminal until rst.
- Only one of gate_pc/gate_base is ever high in a given cycle.
- ld_pc is high only in FETCH1, BR_TAKE, JMP_EX and JSR_JUMP.

Test Plan:
- Reset/start: rst pulse, run=1, mem_ready tied 1, ir=0x1000 (ADD), exec_done 1 cycle after exec_start → states 0,1,2,3,4,9,10,1. Exactly one ld_pc with pc_mux=00 per instruction.
- Branch:
  - ir=0x0A05 (BRnp), nzp=010 → not taken: DECODE→FETCH1, no pc_mux=10.
  - nzp=100 → BR_TAKE with ld_pc=1, pc_mux=10 for 1 cycle.
  - ir=0x0000 → never taken.
- JSR/JSRR/RET:
  - ir=0x4802 → JSR_SAVE (gate_pc, ld_r7) then JSR_JUMP (pc_mux=10).
  - ir=0x4080 → JSR_JUMP with pc_mux=01, gate_base=1.
  - ir=0xC1C0 → JMP_EX with pc_mux=01.
- Memory stall/timeout:
  - mem_ready low for 10 cycles then high → FETCH2 held 11 cycles, mem_req continuous.
  - mem_ready never high → fault=1 after TIMEOUT cycles in FETCH2.
  - mem_ready rising on the timeout cycle → FETCH3, not FAULT.
- HALT/illegal:
  - ir=0xF025 → halted=1 sticky, ld_pc stays 0.
  - ir=0x8000 or 0xD000 → fault=1.
  - ir=0xF023 → EXEC path.
- Async reset mid-operation: assert rst during EXEC_WAIT and during FETCH2 → outputs 0 and state_o=0 before the next clk edge; run=1 restarts at FETCH1.
